// File: rtl/router_pkt_ctrl.sv
// Upstream packet controller for the three router FIFOs.
// Steers header/payload/parity bytes into the addressed FIFO with zero added
// latency, throttles the source, checks parity and silently swallows packets
// that have an invalid address or are aborted by a per-FIFO soft reset.
module router_pkt_ctrl #(
  parameter int NUM_DEST = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                pkt_valid,
  input  logic [7:0]          data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  input  logic [NUM_DEST-1:0] soft_reset,
  output logic                busy,
  output logic [7:0]          data_out,
  output logic [NUM_DEST-1:0] write_enb,
  output logic                lfd_state,
  output logic                parity_done,
  output logic                err,
  output logic                pkt_dropped
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

  state_t     state;
  logic [1:0] dest;
  logic [6:0] rem;
  logic [7:0] acc;

  // Flags padded to the full 2-bit address space so address 3 indexes a
  // well-defined zero instead of running off the end of the vector.
  logic [3:0] full_p, empty_p, srst_p, we_p;
  assign full_p  = {{(4-NUM_DEST){1'b0}}, fifo_full};
  assign empty_p = {{(4-NUM_DEST){1'b0}}, fifo_empty};
  assign srst_p  = {{(4-NUM_DEST){1'b0}}, soft_reset};

  logic [1:0] hdr_addr;
  logic [5:0] hdr_len;
  logic       hdr_ok;
  logic       accept;
  logic       dest_srst;

  assign hdr_addr  = data_in[1:0];
  assign hdr_len   = data_in[7:2];
  assign hdr_ok    = (hdr_addr != 2'b11);
  assign dest_srst = srst_p[dest];
  assign accept    = resetn & pkt_valid & ~busy;
  assign data_out  = data_in;

  // Source throttle: new packets wait for an empty destination, in-flight
  // packets stall on full or on a pending soft-reset abort.
  always_comb begin
    busy = 1'b0;
    if (!resetn) busy = 1'b1;
    else begin
      unique case (state)
        IDLE:           busy = hdr_ok & (full_p[hdr_addr] | ~empty_p[hdr_addr]);
        PAYLOAD,PARITY: busy = full_p[dest] | dest_srst;
        default:        busy = 1'b0;
      endcase
    end
  end

  // One-hot write enable and header marker, valid in the accepting cycle.
  always_comb begin
    we_p      = 4'b0;
    lfd_state = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: if (hdr_ok) begin
          we_p[hdr_addr] = 1'b1;
          lfd_state      = 1'b1;
        end
        PAYLOAD, PARITY: we_p[dest] = 1'b1;
        default: ;
      endcase
    end
  end
  assign write_enb = we_p[NUM_DEST-1:0];

  // Packet FSM: tracks bytes left, running parity and the status pulses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      dest        <= 2'd0;
      rem         <= 7'd0;
      acc         <= 8'd0;
      err         <= 1'b0;
      parity_done <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      parity_done <= 1'b0;
      pkt_dropped <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          if (hdr_ok) begin
            dest <= hdr_addr;
            acc  <= data_in;
            err  <= 1'b0;
            if (hdr_len == 6'd0) state <= PARITY;
            else begin
              rem   <= {1'b0, hdr_len};
              state <= PAYLOAD;
            end
          end else begin
            // Invalid address: payload plus parity still has to be drained.
            rem   <= {1'b0, hdr_len} + 7'd1;
            state <= DROP;
          end
        end
        PAYLOAD: begin
          if (dest_srst) begin
            // Remaining payload plus the parity byte get swallowed.
            rem   <= rem + 7'd1;
            state <= DROP;
          end else if (accept) begin
            acc <= acc ^ data_in;
            rem <= rem - 7'd1;
            if (rem == 7'd1) state <= PARITY;
          end
        end
        PARITY: begin
          if (dest_srst) begin
            rem   <= 7'd1;
            state <= DROP;
          end else if (accept) begin
            parity_done <= 1'b1;
            err         <= (data_in != acc);
            state       <= IDLE;
          end
        end
        default: if (accept) begin
          rem <= rem - 7'd1;
          if (rem == 7'd1) begin
            pkt_dropped <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for router_pkt_ctrl: good/bad parity, full stall, invalid
// address drop, soft-reset abort, empty-wait on header and reset mid-packet.
module tb_router_pkt_ctrl;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid;
  logic [7:0] data_in, data_out;
  logic [2:0] fifo_full, fifo_empty, soft_reset, write_enb;
  logic       busy, lfd_state, parity_done, err, pkt_dropped;

  int n_chk = 0;
  int n_pass = 0;
  int wr_total = 0, pd_total = 0, lfd_total = 0, dr_total = 0;

  router_pkt_ctrl #(.NUM_DEST(3)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .busy(busy), .data_out(data_out), .write_enb(write_enb),
    .lfd_state(lfd_state), .parity_done(parity_done), .err(err),
    .pkt_dropped(pkt_dropped)
  );

  always #5 clock = ~clock;

  // Event counters sampled at the edge; stimulus only changes 1ns after it.
  always @(posedge clock) begin
    if (write_enb != 3'b000) wr_total++;
    if (parity_done)         pd_total++;
    if (lfd_state)           lfd_total++;
    if (pkt_dropped)         dr_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clk_edge;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    pkt_valid = 1'b1;
    data_in   = b;
    #1;
  endtask

  function automatic logic [2:0] onehot(input int a);
    logic [2:0] r;
    r = 3'b000;
    r[a] = 1'b1;
    return r;
  endfunction

  // Header, payload, parity to a valid address. stall_k / srst_k give the
  // byte index (0 = header) before which a full stall / soft reset happens.
  task automatic send_pkt(input logic [7:0] hdr, input bit bad_par,
                          input int stall_k, input int srst_k);
    logic [7:0] b, acc;
    int len, a, w0, p0, l0, d0;
    bit dropped;
    len = int'(hdr[7:2]);
    a   = int'(hdr[1:0]);
    acc = hdr;
    dropped = 1'b0;
    w0 = wr_total; p0 = pd_total; l0 = lfd_total; d0 = dr_total;
    for (int k = 0; k <= len + 1; k++) begin
      if (k == 0)        b = hdr;
      else if (k <= len) begin b = 8'($urandom); acc = acc ^ b; end
      else               b = bad_par ? (acc ^ 8'h01) : acc;
      if (k == stall_k) begin
        fifo_full[a] = 1'b1;
        drive(b);
        for (int s = 0; s < 5; s++) begin
          chk("stall_busy", 32'(busy), 32'd1);
          chk("stall_we", 32'(write_enb), 32'd0);
          clk_edge;
        end
        fifo_full[a] = 1'b0;
      end
      if (k == srst_k) begin
        soft_reset[a] = 1'b1;
        drive(b);
        chk("srst_busy", 32'(busy), 32'd1);
        chk("srst_we", 32'(write_enb), 32'd0);
        clk_edge;
        soft_reset[a] = 1'b0;
        dropped = 1'b1;
      end
      drive(b);
      chk("we", 32'(write_enb), dropped ? 32'd0 : 32'(onehot(a)));
      chk("lfd", 32'(lfd_state), (k == 0) ? 32'd1 : 32'd0);
      chk("data_out", 32'(data_out), 32'(b));
      if (dropped) chk("drop_busy", 32'(busy), 32'd0);
      clk_edge;
      if (k == 0) chk("err_clr_on_hdr", 32'(err), 32'd0);
    end
    pkt_valid = 1'b0;
    if (dropped) begin
      chk("srst_dropped", 32'(pkt_dropped), 32'd1);
      chk("srst_no_pdone", 32'(parity_done), 32'd0);
      chk("srst_writes", 32'(wr_total - w0), 32'(srst_k));
    end else begin
      chk("parity_done", 32'(parity_done), 32'd1);
      chk("err", 32'(err), 32'(bad_par));
      chk("writes", 32'(wr_total - w0), 32'(len + 2));
      chk("no_drop", 32'(dr_total - d0), 32'd0);
    end
    chk("lfd_count", 32'(lfd_total - l0), 32'd1);
    clk_edge;
    chk("pdone_pulse_end", 32'(parity_done), 32'd0);
    chk("drop_pulse_end", 32'(pkt_dropped), 32'd0);
    chk("pdone_count", 32'(pd_total - p0), dropped ? 32'd0 : 32'd1);
  endtask

  // Packet to address 3: every byte swallowed, err left untouched.
  task automatic send_drop(input logic [7:0] hdr, input bit exp_err);
    int len, w0;
    len = int'(hdr[7:2]);
    w0  = wr_total;
    for (int k = 0; k <= len + 1; k++) begin
      drive(8'(k * 17 + 3));
      if (k == 0) drive(hdr);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_we", 32'(write_enb), 32'd0);
      chk("bad_lfd", 32'(lfd_state), 32'd0);
      clk_edge;
      if (k < len + 1) chk("bad_no_drop_yet", 32'(pkt_dropped), 32'd0);
    end
    pkt_valid = 1'b0;
    chk("bad_dropped", 32'(pkt_dropped), 32'd1);
    chk("bad_err_held", 32'(err), 32'(exp_err));
    chk("bad_writes", 32'(wr_total - w0), 32'd0);
    clk_edge;
    chk("bad_drop_end", 32'(pkt_dropped), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b1; data_in = 8'h51;
    fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
    clk_edge; clk_edge;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_we", 32'(write_enb), 32'd0);
    chk("rst_lfd", 32'(lfd_state), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pdone", 32'(parity_done), 32'd0);
    chk("rst_drop", 32'(pkt_dropped), 32'd0);
    resetn = 1'b1; pkt_valid = 1'b0;
    clk_edge;

    send_pkt(8'h51, 1'b0, -1, -1);   // good parity
    send_pkt(8'h51, 1'b1, -1, -1);   // bad parity -> err=1
    send_drop(8'h0F, 1'b1);          // addr 3, err must hold
    send_pkt(8'h51, 1'b0, 11, -1);   // full stall before 11th payload byte
    send_pkt(8'h51, 1'b0, -1, 7);    // soft reset after 6th payload byte
    send_pkt(8'h05, 1'b0, -1, -1);   // next header accepted normally

    // Header to addr 2 waits for FIFO 2 to drain.
    fifo_empty[2] = 1'b0;
    drive(8'h0A);
    for (int s = 0; s < 3; s++) begin
      chk("empty_wait_busy", 32'(busy), 32'd1);
      chk("empty_wait_we", 32'(write_enb), 32'd0);
      clk_edge;
    end
    fifo_empty[2] = 1'b1;
    #1;
    chk("empty_go_busy", 32'(busy), 32'd0);
    chk("empty_go_we", 32'(write_enb), 32'd4);
    chk("empty_go_lfd", 32'(lfd_state), 32'd1);
    clk_edge;
    drive(8'h33);
    chk("p2_we", 32'(write_enb), 32'd4);
    clk_edge;

    // Reset mid-payload abandons the packet.
    resetn = 1'b0;
    drive(8'h44);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_we", 32'(write_enb), 32'd0);
    clk_edge;
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_drop", 32'(pkt_dropped), 32'd0);
    resetn = 1'b1;
    drive(8'h05);                    // must be taken as a header
    chk("post_rst_we", 32'(write_enb), 32'd2);
    chk("post_rst_lfd", 32'(lfd_state), 32'd1);
    clk_edge;
    drive(8'hAA); clk_edge;
    drive(8'h05 ^ 8'hAA);
    chk("post_rst_par_we", 32'(write_enb), 32'd2);
    clk_edge;
    pkt_valid = 1'b0;
    chk("post_rst_pdone", 32'(parity_done), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    clk_edge;

    // Reset during a drop clears a standing err and emits no drop pulse.
    send_pkt(8'h05, 1'b1, -1, -1);
    drive(8'h0F); clk_edge;
    drive(8'h11); clk_edge;
    resetn = 1'b0;
    clk_edge;
    chk("droprst_err", 32'(err), 32'd0);
    resetn = 1'b1; pkt_valid = 1'b0;
    clk_edge;
    chk("droprst_no_drop", 32'(pkt_dropped), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
